// File: rtl/cgol_pkg.sv
// Shared types and the per-cell life rule for the 8x8 Game of Life engine.
//   row_t       : one board row, bit i = column i
//   grid_t      : eight rows, index = row number
//   gen_state_t : generation sequencer states
//   NBR_W       : width of a cell's neighbour vector {NW,N,NE,W,E,SW,S,SE}
//   cell_next() : B3/S23 decision for one cell from its neighbour vector
package cgol_pkg;

  localparam int NBR_W = 8;

  typedef logic [7:0] row_t;
  typedef row_t [7:0] grid_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    SWAP    = 2'd2
  } gen_state_t;

  // A cell lives next generation if it has exactly 3 live neighbours,
  // or if it is already alive and has exactly 2.
  function automatic logic cell_next(input logic self, input logic [NBR_W-1:0] nbr);
    logic [3:0] cnt;
    cnt = '0;
    for (int k = 0; k < NBR_W; k++) begin
      cnt = cnt + {3'b000, nbr[k]};
    end
    return (cnt == 4'd3) || (self && (cnt == 4'd2));
  endfunction

endpackage

// File: rtl/cgol_row_eval.sv
// Combinational next-row evaluator for one board row.
//   above_i : row r-1 (already zeroed by the caller when off-board and WRAP=0)
//   cur_i   : row r
//   below_i : row r+1 (already zeroed by the caller when off-board and WRAP=0)
//   next_o  : row r of the next generation
// WRAP=1 wraps columns 0 and 7 onto each other; WRAP=0 reads them as dead.
module cgol_row_eval
  import cgol_pkg::*;
#(
  parameter int WRAP = 1
) (
  input  row_t above_i,
  input  row_t cur_i,
  input  row_t below_i,
  output row_t next_o
);

  for (genvar i = 0; i < 8; i++) begin : g_col
    localparam int IW    = (i + 7) % 8;
    localparam int IE    = (i + 1) % 8;
    localparam bit HAS_W = (WRAP != 0) || (i > 0);
    localparam bit HAS_E = (WRAP != 0) || (i < 7);

    logic [NBR_W-1:0] nbr;

    assign nbr = {above_i[IW] & HAS_W, above_i[i], above_i[IE] & HAS_E,
                  cur_i[IW]   & HAS_W,             cur_i[IE]   & HAS_E,
                  below_i[IW] & HAS_W, below_i[i], below_i[IE] & HAS_E};

    assign next_o[i] = cell_next(cur_i[i], nbr);
  end

endmodule

// File: rtl/cgol_gen_sequencer.sv
// Generation controller for the 8x8 Game of Life board.
// Holds a double-buffered grid; a generation evaluates one row per cycle
// from the front bank into the back bank, then swaps banks.
//   clk, reset          : clock, asynchronous active-high reset
//   step                : one-cycle request for a generation
//   run                 : auto-step every PERIOD cycles while high
//   load_en/addr/data   : write a front-bank row (honoured only when idle)
//   disp_addr/disp_data : registered front-bank row read for the display
//   busy                : high during COMPUTE and SWAP
//   done                : one-cycle pulse after SWAP
//   stable, extinct     : last generation unchanged / front bank empty
//   gen_count           : completed generations (wraps)
module cgol_gen_sequencer
  import cgol_pkg::*;
#(
  parameter int PERIOD = 25_000_000,
  parameter int WRAP   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  input  logic        run,
  input  logic        load_en,
  input  logic [2:0]  load_addr,
  input  logic [7:0]  load_data,
  input  logic [2:0]  disp_addr,
  output logic [7:0]  disp_data,
  output logic        busy,
  output logic        done,
  output logic        stable,
  output logic        extinct,
  output logic [15:0] gen_count
);

  localparam int              CNT_W    = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  grid_t            bank0_q, bank1_q;
  logic             front_sel_q;
  gen_state_t       state_q, state_d;
  logic [2:0]       row_q;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             diff_q;
  logic             done_q, stable_q, extinct_q;
  logic [15:0]      gen_q;
  row_t             disp_q;

  grid_t front, back;
  row_t  above, cur, below, next_row;
  logic  idle, load_ok, auto_hit, start;

  assign front = front_sel_q ? bank1_q : bank0_q;
  assign back  = front_sel_q ? bank0_q : bank1_q;

  // Rows 0 and 7 wrap vertically only on a toroidal board.
  assign cur   = front[row_q];
  assign above = ((WRAP == 0) && (row_q == 3'd0)) ? '0 : front[row_q - 3'd1];
  assign below = ((WRAP == 0) && (row_q == 3'd7)) ? '0 : front[row_q + 3'd1];

  cgol_row_eval #(.WRAP(WRAP)) u_row_eval (
    .above_i (above),
    .cur_i   (cur),
    .below_i (below),
    .next_o  (next_row)
  );

  assign idle    = (state_q == IDLE);
  assign load_ok = idle && load_en;
  // The done cycle closes out the previous generation and is not counted,
  // so an auto-stepped generation repeats every PERIOD + 10 cycles.
  assign auto_hit = idle && run && !done_q && (cnt_q == CNT_LAST);
  // A load takes priority over starting: the start is deferred through
  // pending so the new generation sees the freshly loaded row.
  assign start = idle && !load_en && (step || pending_q || auto_hit);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = COMPUTE;
      COMPUTE: if (row_q == 3'd7) state_d = SWAP;
      SWAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    if (start) begin
      pending_d = 1'b0;
    end else if (!idle && step) begin
      pending_d = 1'b1;
    end else if (load_ok && (step || auto_hit)) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!run || auto_hit) begin
      cnt_d = '0;
    end else if (idle && !done_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank0_q     <= '0;
      bank1_q     <= '0;
      front_sel_q <= 1'b0;
      state_q     <= IDLE;
      row_q       <= 3'd0;
      pending_q   <= 1'b0;
      cnt_q       <= '0;
      diff_q      <= 1'b0;
      done_q      <= 1'b0;
      stable_q    <= 1'b0;
      extinct_q   <= 1'b0;
      gen_q       <= 16'd0;
      disp_q      <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      done_q    <= (state_q == SWAP);
      disp_q    <= front[disp_addr];

      if (start) begin
        row_q  <= 3'd0;
        diff_q <= 1'b0;
      end else if (state_q == COMPUTE) begin
        row_q  <= row_q + 3'd1;
        diff_q <= diff_q | (next_row != cur);
        if (front_sel_q) bank0_q[row_q] <= next_row;
        else             bank1_q[row_q] <= next_row;
      end

      if (load_ok) begin
        if (front_sel_q) bank1_q[load_addr] <= load_data;
        else             bank0_q[load_addr] <= load_data;
        stable_q  <= 1'b0;
        extinct_q <= 1'b0;
      end

      // The back bank is complete here and becomes the new front.
      if (state_q == SWAP) begin
        front_sel_q <= ~front_sel_q;
        gen_q       <= gen_q + 16'd1;
        stable_q    <= ~diff_q;
        extinct_q   <= (back == '0);
      end
    end
  end

  assign disp_data = disp_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign stable    = stable_q;
  assign extinct   = extinct_q;
  assign gen_count = gen_q;

endmodule

// File: tb/tb_cgol_gen_sequencer.sv
// Scoreboard bench for cgol_gen_sequencer: a toroidal unit and a bounded-edge
// unit share all inputs; sel picks which one the monitor observes.
module tb_cgol_gen_sequencer;
  import cgol_pkg::*;

  logic        clk = 1'b0;
  logic        reset, step, run, load_en;
  logic [2:0]  load_addr, disp_addr;
  logic [7:0]  load_data;
  logic [7:0]  disp1, disp0;
  logic        busy1, busy0, done1, done0, stable1, stable0, ext1, ext0;
  logic [15:0] gen1, gen0;

  always #5 clk = ~clk;

  cgol_gen_sequencer #(.PERIOD(16), .WRAP(1)) dut (
    .clk(clk), .reset(reset), .step(step), .run(run), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .disp_addr(disp_addr),
    .disp_data(disp1), .busy(busy1), .done(done1), .stable(stable1),
    .extinct(ext1), .gen_count(gen1));

  cgol_gen_sequencer #(.PERIOD(16), .WRAP(0)) dut0 (
    .clk(clk), .reset(reset), .step(step), .run(run), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .disp_addr(disp_addr),
    .disp_data(disp0), .busy(busy0), .done(done0), .stable(stable0),
    .extinct(ext0), .gen_count(gen0));

  logic        sel;
  logic [7:0]  disp_m;
  logic        busy_m, done_m, stable_m, ext_m;
  logic [15:0] gen_m;
  assign disp_m   = sel ? disp1   : disp0;
  assign busy_m   = sel ? busy1   : busy0;
  assign done_m   = sel ? done1   : done0;
  assign stable_m = sel ? stable1 : stable0;
  assign ext_m    = sel ? ext1    : ext0;
  assign gen_m    = sel ? gen1    : gen0;

  typedef struct {
    string name;
    int    gen;
    logic  stable;
    logic  extinct;
  } done_exp_t;

  typedef struct {
    string      name;
    int         row;
    logic [7:0] val;
  } rd_exp_t;

  done_exp_t done_q[$];
  rd_exp_t   rd_q[$];
  done_exp_t de;
  rd_exp_t   re;

  int   tests = 0;
  int   fails = 0;
  int   done_seen = 0;
  int   cyc = 0;
  int   last_done = -1;
  logic gap_en = 1'b0;
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations when the DUT presents a read or a done pulse.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_vld <= rd_req;
  end

  always @(negedge clk) begin
    if (rd_vld) begin
      tests++;
      if (rd_q.size() == 0) begin
        fails++;
        $display("FAIL disp_unexpected: got %0h, expected no read", disp_m);
      end else begin
        tests--;
        re = rd_q.pop_front();
        chk($sformatf("%s_row%0d", re.name, re.row), 64'(disp_m), 64'(re.val));
      end
    end
    if (done_m) begin
      done_seen++;
      if (gap_en && (last_done >= 0)) chk("done_gap", 64'(cyc - last_done), 64'd26);
      last_done = cyc;
      tests++;
      if (done_q.size() == 0) begin
        fails++;
        $display("FAIL done_unexpected: got done at cycle %0d, expected none", cyc);
      end else begin
        tests--;
        de = done_q.pop_front();
        chk({de.name, "_gen"},     64'(gen_m),    64'(de.gen));
        chk({de.name, "_stable"},  64'(stable_m), 64'(de.stable));
        chk({de.name, "_extinct"}, 64'(ext_m),    64'(de.extinct));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; step = 1'b0; run = 1'b0; load_en = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic load_row(input int r, input logic [7:0] d);
    load_addr = 3'(r); load_data = d; load_en = 1'b1;
    tick(1);
    load_en = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick(1);
    step = 1'b0;
  endtask

  task automatic exp_done(input string name, input int gen, input logic st, input logic ex);
    de.name = name; de.gen = gen; de.stable = st; de.extinct = ex;
    done_q.push_back(de);
  endtask

  task automatic wait_done(input string name);
    int start_seen;
    int k;
    start_seen = done_seen;
    k = 0;
    while ((done_seen == start_seen) && (k < 80)) begin
      tick(1);
      k++;
    end
    if (done_seen == start_seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done in 80 cycles, expected done", name);
    end
  endtask

  task automatic read_grid(input string name, input grid_t g);
    rd_exp_t e;
    for (int r = 0; r < 8; r++) begin
      disp_addr = 3'(r);
      rd_req = 1'b1;
      e.name = name; e.row = r; e.val = g[r];
      rd_q.push_back(e);
      tick(1);
    end
    rd_req = 1'b0;
    tick(2);
  endtask

  grid_t blink_h, blink_v, blk, zero_g, trom, blk01, glider;
  int    busy_n, done_k, seen0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    blink_h = '0; blink_h[2] = 8'b00011100;
    blink_v = '0; blink_v[1] = 8'b00001000; blink_v[2] = 8'b00001000; blink_v[3] = 8'b00001000;
    blk = '0; blk[3] = 8'b00011000; blk[4] = 8'b00011000;
    zero_g = '0;
    trom = '0; trom[0] = 8'b00000011; trom[1] = 8'b00000001;
    blk01 = '0; blk01[0] = 8'b00000011; blk01[1] = 8'b00000011;
    glider = '0; glider[0] = 8'b00000010; glider[1] = 8'b00000100; glider[2] = 8'b00000111;

    reset = 1'b1; step = 1'b0; run = 1'b0; load_en = 1'b0;
    load_addr = '0; load_data = '0; disp_addr = '0; sel = 1'b1;
    tick(2);
    chk("rst_busy",    64'(busy_m),   64'd0);
    chk("rst_done",    64'(done_m),   64'd0);
    chk("rst_stable",  64'(stable_m), 64'd0);
    chk("rst_extinct", 64'(ext_m),    64'd0);
    chk("rst_gen",     64'(gen_m),    64'd0);
    chk("rst_disp",    64'(disp_m),   64'd0);
    reset = 1'b0;
    tick(1);

    // Blinker oscillates between horizontal and vertical.
    do_reset();
    load_row(2, 8'b00011100);
    exp_done("blinker1", 1, 1'b0, 1'b0);
    pulse_step();
    wait_done("blinker1");
    read_grid("blinker1", blink_v);
    exp_done("blinker2", 2, 1'b0, 1'b0);
    pulse_step();
    wait_done("blinker2");
    read_grid("blinker2", blink_h);

    // Block still life, with exact busy/done timing.
    do_reset();
    load_row(3, 8'b00011000);
    load_row(4, 8'b00011000);
    exp_done("block", 1, 1'b1, 1'b0);
    busy_n = 0; done_k = -1;
    step = 1'b1;
    tick(1);
    step = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (busy_m) busy_n++;
      if (done_m && (done_k < 0)) done_k = k;
      tick(1);
    end
    chk("block_busy_cycles", 64'(busy_n), 64'd9);
    chk("block_done_latency", 64'(done_k), 64'd10);
    read_grid("block", blk);
    load_row(0, 8'h00);
    chk("load_clears_stable", 64'(stable_m), 64'd0);

    // Lone cell dies.
    do_reset();
    load_row(0, 8'b00000001);
    exp_done("lone", 1, 1'b0, 1'b1);
    pulse_step();
    wait_done("lone");
    read_grid("lone", zero_g);

    // Corner L-tromino becomes a block on both board types.
    do_reset();
    load_row(0, 8'b00000011);
    load_row(1, 8'b00000001);
    sel = 1'b0;
    exp_done("trom_nowrap", 1, 1'b0, 1'b0);
    pulse_step();
    wait_done("trom_nowrap");
    read_grid("trom_nowrap", blk01);
    sel = 1'b1;
    read_grid("trom_wrap", blk01);
    chk("trom_wrap_gen", 64'(gen_m), 64'd1);
    chk("trom_wrap_extinct", 64'(ext_m), 64'd0);

    // Steps while busy: one queued, extra dropped; busy loads ignored.
    do_reset();
    load_row(2, 8'b00011100);
    exp_done("pend1", 1, 1'b0, 1'b0);
    exp_done("pend2", 2, 1'b0, 1'b0);
    pulse_step();
    tick(2);
    pulse_step();
    load_addr = 3'd5; load_data = 8'hFF; load_en = 1'b1;
    tick(1);
    load_en = 1'b0;
    pulse_step();
    wait_done("pend1");
    wait_done("pend2");
    read_grid("pend", blink_h);
    seen0 = done_seen;
    tick(40);
    chk("extra_step_dropped", 64'(done_seen - seen0), 64'd0);
    chk("pend_gen_final", 64'(gen_m), 64'd2);

    // Glider on the torus under the period timer returns home after 32.
    do_reset();
    load_row(0, 8'b00000010);
    load_row(1, 8'b00000100);
    load_row(2, 8'b00000111);
    for (int g = 1; g <= 32; g++) exp_done($sformatf("glider%0d", g), g, 1'b0, 1'b0);
    last_done = -1;
    gap_en = 1'b1;
    run = 1'b1;
    for (int g = 1; g <= 32; g++) wait_done("glider");
    run = 1'b0;
    gap_en = 1'b0;
    read_grid("glider_home", glider);

    // Asynchronous reset in the middle of a generation.
    do_reset();
    load_row(2, 8'b00011100);
    exp_done("pre_reset", 1, 1'b0, 1'b0);
    pulse_step();
    wait_done("pre_reset");
    disp_addr = 3'd2;
    pulse_step();
    tick(4);
    chk("pre_rst_disp", 64'(disp_m), 64'h08);
    reset = 1'b1;
    #1;
    chk("midrst_busy",    64'(busy_m),   64'd0);
    chk("midrst_done",    64'(done_m),   64'd0);
    chk("midrst_stable",  64'(stable_m), 64'd0);
    chk("midrst_extinct", 64'(ext_m),    64'd0);
    chk("midrst_gen",     64'(gen_m),    64'd0);
    chk("midrst_disp",    64'(disp_m),   64'd0);
    tick(1);
    reset = 1'b0;
    tick(1);
    read_grid("midrst", zero_g);
    busy_n = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy_m) busy_n++;
      tick(1);
    end
    chk("midrst_stays_idle", 64'(busy_n), 64'd0);

    chk("done_queue_drained", 64'(done_q.size()), 64'd0);
    chk("read_queue_drained", 64'(rd_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cgol_gen_sequencer.md
Name: cgol_gen_sequencer

Overview:
Generation controller for the 8x8 Game of Life board. It holds a double-buffered 8x8 cell grid and computes the next generation one row per cycle into the back bank. At the end of each generation it swaps the banks. It also serves row reads to the LED display controller and accepts row loads of an initial pattern. Generations start on a single-step pulse or on a free-running period timer.

Parameters:
- PERIOD, 25_000_000, clk cycles between automatic generations while run=1 (must be >=16)
- WRAP, 1, 1 = toroidal board edges; 0 = cells outside the board read as dead

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state
- step  in  1  single-cycle request for one generation
- run  in  1  level; auto-step every PERIOD cycles while high
- load_en  in  1  write load_data into front-bank row load_addr
- load_addr  in  3  row index for load
- load_data  in  8  row contents; bit i = column i
- disp_addr  in  3  display row select
- disp_data  out  8  front-bank row disp_addr, registered
- busy  out  1  high in COMPUTE and SWAP
- done  out  1  one-cycle pulse, the cycle after SWAP
- stable  out  1  last generation equalled its predecessor
- extinct  out  1  front bank is all zero after last swap
- gen_count  out  16  generations completed, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (async):
  - both banks are 0; front_sel = 0; state = IDLE; row = 0; pending = 0; period counter = 0.
  - All outputs are 0.
- Cell rule is B3/S23: a live cell with 2 or 3 live neighbours survives; a dead cell with exactly 3 is born.
- Neighbour vector order is {NW,N,NE,W,E,SW,S,SE}.
- Row r neighbours are rows r-1 and r+1; column i neighbours are columns i-1 and i+1. Indices wrap mod 8 when WRAP=1; otherwise out-of-range cells read 0.
- FSM states: IDLE, COMPUTE, SWAP.
- IDLE -> COMPUTE with row = 0 when any of these is true (sampled this edge): step, pending, or period counter == PERIOD-1 while run=1. Starting clears pending.
- COMPUTE:
  - Each cycle, back[row] <= next(front[row-1], front[row], front[row+1]).
  - A running diff flag ORs (back[row] != front[row]).
  - row increments; at row == 7 the next state is SWAP.
- SWAP:
  - front_sel toggles and gen_count increments.
  - stable <= ~diff; extinct <= (new front == 0).
  - Next state is IDLE; done = 1 for that following IDLE cycle.
- Latency: step high at edge N gives busy at N+1..N+9 and done at N+10. The new front bank is visible to disp_data from a disp_addr presented at N+10, with data returned at N+11.
- Step while busy sets pending (one deep; further steps are dropped). The next generation starts the cycle after SWAP.
- load_en:
  - Honoured only in IDLE; it writes front[load_addr]. Ignored when busy.
  - Load and step in the same IDLE cycle: the load is applied, step becomes pending, and COMPUTE starts next cycle using the loaded data.
  - A load clears stable and extinct.
- Period counter:
  - Counts only while run=1 and in IDLE; resets to 0 on auto-start.
  - Held at 0 while run=0.
- disp_data <= front[disp_addr] every cycle, regardless of state. The display never stalls; during COMPUTE it shows the old generation.
- Reset mid-COMPUTE: immediate return to the reset state. The partial back bank is discarded; gen_count = 0.

Decomposition:
- cgol_pkg holds:
  - typedef row_t = logic[7:0]
  - typedef grid_t = row_t[7:0]
  - enum gen_state_t {IDLE, COMPUTE, SWAP}
  - constant NBR_W = 8
- Sub-module cgol_row_eval: combinational; inputs above, cur, below rows plus WRAP; outputs the next row. It instantiates 8 copies of the existing decoder cell with the neighbour ordering above.
- The sequencer owns the banks, FSM, timers and flags.

Test Plan:
- Blinker, WRAP=1: load row 2 = 8'b00011100, all other rows 0; pulse step.
  - At done: rows 1, 2, 3 = 8'b00001000, others 0; gen_count = 1; stable = 0; extinct = 0.
  - A second step restores row 2 = 8'b00011100.
- Block still life: rows 3 and 4 = 8'b00011000; step.
  - Grid unchanged; stable = 1; done exactly 10 cycles after step; busy high for exactly 9 cycles.
- Lone cell: row 0 = 8'b00000001; step.
  - extinct = 1; all disp_data reads = 0.
  - With WRAP=0, a corner L-tromino (row0 = 8'b00000011, row1 = 8'b00000001) gives a 2x2 block. With WRAP=1, the same pattern gives the same result (edge-wrap check).
- Step during COMPUTE cycle 3, plus a third step in the same generation:
  - Exactly two generations run back-to-back; gen_count = 2; the extra step is dropped.
  - load_en during busy leaves the grid unchanged.
- Glider, WRAP=1, PERIOD=16, run=1:
  - After 32 done pulses the grid equals the initial pattern.
  - Consecutive done pulses are spaced 26 cycles apart.
- Assert reset at COMPUTE row 4:
  - All outputs return to 0 within the same cycle; disp_data reads 0 for all rows.
  - The FSM stays in IDLE until a step.
